// File: rtl/stack_mem_pkg.sv
// Shared types and constants for the stack memory unit: stack opcode
// encoding and the bit positions of the sticky fault vector.
package stack_mem_pkg;

  typedef enum logic [2:0] {
    STK_NOP     = 3'd0,
    STK_PUSH    = 3'd1,
    STK_POP     = 3'd2,
    STK_XCHG    = 3'd3,
    STK_LOAD_SP = 3'd4
  } stk_op_e;

  localparam int FAULT_W       = 4;
  localparam int FLT_WR_PROT   = 0;  // write port above its limit
  localparam int FLT_OVERFLOW  = 1;  // push below the stack floor
  localparam int FLT_UNDERFLOW = 2;  // pop/xchg past top of memory
  localparam int FLT_BAD_OP    = 3;  // reserved opcode or stack/write-port collision

endpackage

// File: rtl/stack_mem_unit_if.sv
// Bus bundle between the core's decode/execute stages and the unified
// byte memory: fetch port, data read port, data write port and stack port.
interface stack_mem_unit_if #(
  parameter int AW = 16,
  parameter int FB = 3,
  parameter int DB = 2
);
  logic [AW-1:0]                      fetch_addr;
  logic [8*FB-1:0]                    fetch_data;
  logic [AW-1:0]                      rd_addr;
  logic [8*DB-1:0]                    rd_data;
  logic                               wr_en;
  logic [AW-1:0]                      wr_addr;
  logic [8*DB-1:0]                    wr_data;
  logic [2:0]                         stk_op;
  logic [8*DB-1:0]                    stk_wdata;
  logic [8*DB-1:0]                    stk_rdata;
  logic                               stk_valid;
  logic [AW:0]                        sp;
  logic [stack_mem_pkg::FAULT_W-1:0]  fault;
  logic                               fault_clr;

  modport master (
    output fetch_addr, rd_addr, wr_en, wr_addr, wr_data, stk_op, stk_wdata, fault_clr,
    input  fetch_data, rd_data, stk_rdata, stk_valid, sp, fault
  );

  modport slave (
    input  fetch_addr, rd_addr, wr_en, wr_addr, wr_data, stk_op, stk_wdata, fault_clr,
    output fetch_data, rd_data, stk_rdata, stk_valid, sp, fault
  );
endinterface

// File: rtl/stack_mem_unit_stack_ctrl.sv
// Stack engine: owns the stack pointer, decodes the stack opcode, applies
// the overflow/underflow/write-protect range checks and keeps the sticky
// fault register. Produces the byte-array write/read requests for the top.
module stack_mem_unit_stack_ctrl
  import stack_mem_pkg::*;
#(
  parameter int            AW          = 16,
  parameter int            DB          = 2,
  parameter logic [AW-1:0] STACK_LIMIT = 16'hC000,
  parameter logic [AW-1:0] WR_LIMIT    = 16'hBFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         stk_op_i,
  input  logic [AW-1:0]      new_sp_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic               fault_clr_i,
  output logic [AW:0]        sp_o,
  output logic               stk_we_o,
  output logic [AW-1:0]      stk_base_o,
  output logic               stk_rd_o,
  output logic               wr_ok_o,
  output logic               stk_valid_o,
  output logic [FAULT_W-1:0] fault_o
);

  localparam logic [AW:0]   SP_RESET = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   DB_W     = (AW+1)'(DB);
  // Checks are done one bit wider than sp so sp-DB can never wrap.
  localparam logic [AW+1:0] PUSH_MIN = (AW+2)'(STACK_LIMIT) + (AW+2)'(DB);
  localparam logic [AW+1:0] POP_MAX  = {2'b01, {AW{1'b0}}} - (AW+2)'(DB);

  logic [AW:0]        sp_q, sp_d;
  logic [FAULT_W-1:0] fault_q, fault_d, fault_ev_s;
  logic               stk_valid_q;
  logic [AW+1:0]      sp_ext_s;
  logic               push_ok_s, pop_ok_s, wr_ok_s;
  logic               stk_we_s, stk_rd_s;
  logic [AW-1:0]      stk_base_s;

  assign sp_ext_s  = {1'b0, sp_q};
  assign push_ok_s = (sp_ext_s >= PUSH_MIN);
  assign pop_ok_s  = (sp_ext_s <= POP_MAX);
  assign wr_ok_s   = wr_en_i && (wr_addr_i <= WR_LIMIT);

  // Opcode decode: next sp, stack byte-array requests and fault events.
  always_comb begin
    sp_d       = sp_q;
    stk_we_s   = 1'b0;
    stk_rd_s   = 1'b0;
    stk_base_s = sp_q[AW-1:0];
    fault_ev_s = {FAULT_W{1'b0}};
    fault_ev_s[FLT_WR_PROT] = wr_en_i && !wr_ok_s;
    case (stk_op_i)
      STK_NOP: sp_d = sp_q;
      STK_PUSH: begin
        if (push_ok_s) begin
          sp_d       = sp_q - DB_W;
          stk_we_s   = 1'b1;
          stk_base_s = sp_q[AW-1:0] - AW'(DB);
        end else begin
          fault_ev_s[FLT_OVERFLOW] = 1'b1;
        end
      end
      STK_POP: begin
        if (pop_ok_s) begin
          sp_d     = sp_q + DB_W;
          stk_rd_s = 1'b1;
        end else begin
          fault_ev_s[FLT_UNDERFLOW] = 1'b1;
        end
      end
      STK_XCHG: begin
        if (pop_ok_s) begin
          stk_rd_s = 1'b1;
          stk_we_s = 1'b1;
        end else begin
          fault_ev_s[FLT_UNDERFLOW] = 1'b1;
        end
      end
      STK_LOAD_SP: sp_d = {1'b0, new_sp_i};
      default: fault_ev_s[FLT_BAD_OP] = 1'b1;
    endcase
    // Any byte written by both the stack and the write port this cycle.
    for (int i = 0; i < DB; i++) begin
      for (int j = 0; j < DB; j++) begin
        fault_ev_s[FLT_BAD_OP] = fault_ev_s[FLT_BAD_OP] |
          (stk_we_s && wr_ok_s && ((stk_base_s + AW'(i)) == (wr_addr_i + AW'(j))));
      end
    end
  end

  // A new event wins over a clear in the same cycle.
  assign fault_d = (fault_clr_i ? {FAULT_W{1'b0}} : fault_q) | fault_ev_s;

  // Stack pointer, sticky faults and the pop/xchg result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q        <= SP_RESET;
      fault_q     <= {FAULT_W{1'b0}};
      stk_valid_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      fault_q     <= fault_d;
      stk_valid_q <= stk_rd_s;
    end
  end

  assign sp_o        = sp_q;
  assign stk_we_o    = stk_we_s;
  assign stk_base_o  = stk_base_s;
  assign stk_rd_o    = stk_rd_s;
  assign wr_ok_o     = wr_ok_s;
  assign stk_valid_o = stk_valid_q;
  assign fault_o     = fault_q;

endmodule

// File: rtl/stack_mem_unit.sv
// Unified byte memory for the 8080 core: wide fetch port, data read port,
// data write port and the stack engine. Reads are registered and
// read-first; stack writes override the write port on shared bytes.
module stack_mem_unit
  import stack_mem_pkg::*;
#(
  parameter int            AW          = 16,
  parameter int            FETCH_BYTES = 3,
  parameter int            DATA_BYTES  = 2,
  parameter logic [AW-1:0] STACK_LIMIT = 16'hC000,
  parameter logic [AW-1:0] WR_LIMIT    = 16'hBFFF
) (
  input logic             clk,
  input logic             rst_n,
  stack_mem_unit_if.slave bus
);

  localparam int FB = FETCH_BYTES;
  localparam int DB = DATA_BYTES;

  logic [7:0]         mem_q [2**AW];
  logic [8*FB-1:0]    fetch_data_q;
  logic [8*DB-1:0]    rd_data_q;
  logic [8*DB-1:0]    stk_rdata_q;
  logic [AW:0]        sp_s;
  logic               stk_we_s, stk_rd_s, wr_ok_s, stk_valid_s;
  logic [AW-1:0]      stk_base_s;
  logic [FAULT_W-1:0] fault_s;

  stack_mem_unit_stack_ctrl #(
    .AW          (AW),
    .DB          (DB),
    .STACK_LIMIT (STACK_LIMIT),
    .WR_LIMIT    (WR_LIMIT)
  ) u_stack_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .stk_op_i    (bus.stk_op),
    .new_sp_i    (bus.stk_wdata[AW-1:0]),
    .wr_en_i     (bus.wr_en),
    .wr_addr_i   (bus.wr_addr),
    .fault_clr_i (bus.fault_clr),
    .sp_o        (sp_s),
    .stk_we_o    (stk_we_s),
    .stk_base_o  (stk_base_s),
    .stk_rd_o    (stk_rd_s),
    .wr_ok_o     (wr_ok_s),
    .stk_valid_o (stk_valid_s),
    .fault_o     (fault_s)
  );

  // Byte-array writes: write port big-endian, stack little-endian and last so it wins; none during reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_s) begin
      for (int j = 0; j < DB; j++) begin
        mem_q[bus.wr_addr + AW'(j)] <= bus.wr_data[8*(DB-1-j) +: 8];
      end
    end else begin
      for (int j = 0; j < DB; j++) begin
        mem_q[bus.wr_addr + AW'(j)] <= mem_q[bus.wr_addr + AW'(j)];
      end
    end
    if (rst_n && stk_we_s) begin
      for (int i = 0; i < DB; i++) begin
        mem_q[stk_base_s + AW'(i)] <= bus.stk_wdata[8*i +: 8];
      end
    end
  end

  // Registered read ports; addresses wrap, old data seen on same-cycle writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data_q <= {(8*FB){1'b0}};
      rd_data_q    <= {(8*DB){1'b0}};
      stk_rdata_q  <= {(8*DB){1'b0}};
    end else begin
      for (int k = 0; k < FB; k++) begin
        fetch_data_q[8*(FB-1-k) +: 8] <= mem_q[bus.fetch_addr + AW'(k)];
      end
      for (int k = 0; k < DB; k++) begin
        rd_data_q[8*(DB-1-k) +: 8] <= mem_q[bus.rd_addr + AW'(k)];
      end
      if (stk_rd_s) begin
        for (int i = 0; i < DB; i++) begin
          stk_rdata_q[8*i +: 8] <= mem_q[stk_base_s + AW'(i)];
        end
      end else begin
        stk_rdata_q <= stk_rdata_q;
      end
    end
  end

  assign bus.fetch_data = fetch_data_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.stk_rdata  = stk_rdata_q;
  assign bus.stk_valid  = stk_valid_s;
  assign bus.sp         = sp_s;
  assign bus.fault      = fault_s;

endmodule
